uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_TX_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit strictly after 'last', wrapping.
module rr_picker
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic               found,
   output logic [IW-1:0]      idx
);

   // scan last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins
   always_comb begin : pick
      int j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = int'(last) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// One byte is accepted in IDLE, launched in ISSUE, then the block waits for
// tx_done (or gives up after TIMEOUT_CYC cycles) before accepting the next.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int DATA_W      = UART_DATA_W,
   parameter  int TIMEOUT_CYC = UART_TX_TIMEOUT,
   localparam int IW          = $clog2(NUM_REQ),
   localparam int CW          = $clog2(TIMEOUT_CYC)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic [IW-1:0]             grant_id,
   output logic                      busy,
   output logic                      timeout_err
);

   arb_state_t        state, state_nxt;
   logic [IW-1:0]     last_grant;
   logic [IW-1:0]     grant_id_q;
   logic [DATA_W-1:0] tx_data_q;
   logic [CW-1:0]     cnt;
   logic              timeout_q;
   logic              pick_found;
   logic [IW-1:0]     pick_idx;
   logic              grant_en;
   logic              timeout_set;
   logic              cnt_term;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req_valid),
      .last  (last_grant),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign cnt_term = (cnt == CW'(TIMEOUT_CYC - 1));

   // next-state and strobes; tx_done only matters in WAIT_DONE and beats the timeout
   always_comb begin
      state_nxt   = state;
      grant_en    = 1'b0;
      req_ready   = '0;
      tx_valid    = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found && reset_n) begin
               grant_en            = 1'b1;
               req_ready[pick_idx] = 1'b1;
               state_nxt           = ISSUE;
            end
         end
         ISSUE: begin
            tx_valid  = 1'b1;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end else if (cnt_term) begin
               timeout_set = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // capture winner and its byte on accept; held until the next grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= IW'(NUM_REQ - 1);
         grant_id_q <= '0;
         tx_data_q  <= '0;
      end else if (grant_en) begin
         last_grant <= pick_idx;
         grant_id_q <= pick_idx;
         tx_data_q  <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
      end
   end

   // wait counter: cleared on launch, counts in WAIT_DONE, saturates at terminal
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        cnt <= '0;
      else if (state == ISSUE)             cnt <= '0;
      else if (state == WAIT_DONE && !cnt_term) cnt <= cnt + 1'b1;
   end

   // one-cycle abandon pulse, visible in the first IDLE cycle after giving up
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) timeout_q <= 1'b0;
      else          timeout_q <= timeout_set;
   end

   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign busy        = (state != IDLE);
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, 16-cycle timeout).
module tb_uart_tx_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;
   int last_g = 3;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // reference rule: first pending requester after the last grant, wrapping
   function automatic int rr_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++)
         if (v[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic pulse_done();
      @(negedge clk); tx_done = 1'b1; #1;
      @(negedge clk); tx_done = 1'b0; #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 4'hF; req_data = $urandom; tx_done = 1'b0;
      step(); step();
      total++;
      if ({req_ready, tx_valid, busy, grant_id, tx_data, timeout_err} !== 16'h0) begin
         bad++;
         $display("FAIL reset_outputs: got ready=%b txv=%b busy=%b gid=%0d data=%h err=%b want all zero",
                  req_ready, tx_valid, busy, grant_id, tx_data, timeout_err);
      end
      @(negedge clk); req_valid = 4'h0; reset_n = 1'b1; #1;
      last_g = 3;
   endtask

   task automatic test_single();
      int hold_bad = 0;
      @(negedge clk); req_valid = 4'b0001; req_data = 32'h0000_00A5; #1;
      total++;
      if ({req_ready, busy} !== {4'b0001, 1'b0}) begin
         bad++; $display("FAIL single_accept: got ready=%b busy=%b want 0001/0", req_ready, busy);
      end
      last_g = 0;
      @(negedge clk); req_valid = 4'b0000; #1;
      total++;
      if ({tx_valid, tx_data, grant_id, busy, req_ready} !== {1'b1, 8'hA5, 2'd0, 1'b1, 4'b0}) begin
         bad++; $display("FAIL single_launch: got txv=%b data=%h gid=%0d busy=%b ready=%b want 1/a5/0/1/0000",
                         tx_valid, tx_data, grant_id, busy, req_ready);
      end
      repeat (3) begin
         step();
         if (busy !== 1'b1 || tx_valid !== 1'b0) hold_bad++;
      end
      total++;
      if (hold_bad != 0) begin
         bad++; $display("FAIL single_wait: got %0d bad wait cycles want 0", hold_bad);
      end
      pulse_done();
      total++;
      if ({busy, tx_data} !== {1'b0, 8'hA5}) begin
         bad++; $display("FAIL single_done: got busy=%b data=%h want 0/a5", busy, tx_data);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] d [4];
      int multi = 0;
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      @(negedge clk); req_data = {d[3], d[2], d[1], d[0]}; req_valid = 4'hF; #1;
      for (int g = 0; g < 5; g++) begin
         int w = 0;
         int exp_w;
         while (req_ready == 4'h0 && w < 20) begin step(); w++; end
         exp_w = rr_pick(4'hF, last_g);
         total++;
         if (req_ready !== 4'(1 << exp_w)) begin
            bad++; $display("FAIL rr_grant%0d: got ready=%b want %0d", g, req_ready, exp_w);
         end
         last_g = exp_w;
         step();
         total++;
         if ({tx_valid, tx_data, grant_id} !== {1'b1, d[exp_w], 2'(exp_w)}) begin
            bad++; $display("FAIL rr_launch%0d: got txv=%b data=%h gid=%0d want 1/%h/%0d",
                            g, tx_valid, tx_data, grant_id, d[exp_w], exp_w);
         end
         repeat (9) begin
            step();
            if (req_ready !== 4'h0) multi++;
         end
         @(negedge clk); tx_done = 1'b1; if (g == 4) req_valid = 4'h0; #1;
         @(negedge clk); tx_done = 1'b0; #1;
         if (!$onehot0(req_ready)) multi++;
      end
      total++;
      if (multi != 0) begin
         bad++; $display("FAIL rr_ready_onehot: got %0d bad cycles want 0", multi);
      end
   endtask

   task automatic test_wrap();
      int exp_w;
      @(negedge clk); req_data = $urandom; req_valid = 4'b0100; #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL wrap_first: got ready=%b want 0100", req_ready);
      end
      last_g = 2;
      @(negedge clk); req_valid = 4'b0000; #1;
      pulse_done();
      @(negedge clk); req_valid = 4'b0101; #1;
      exp_w = rr_pick(4'b0101, last_g);
      total++;
      if (req_ready !== 4'(1 << exp_w) || exp_w != 0) begin
         bad++; $display("FAIL wrap_to0: got ready=%b want %0d", req_ready, exp_w);
      end
      last_g = exp_w;
      step();
      total++;
      if ({tx_valid, grant_id} !== {1'b1, 2'd0}) begin
         bad++; $display("FAIL wrap_gid0: got txv=%b gid=%0d want 1/0", tx_valid, grant_id);
      end
      pulse_done();
      exp_w = rr_pick(4'b0101, last_g);
      total++;
      if (req_ready !== 4'(1 << exp_w)) begin
         bad++; $display("FAIL wrap_then2: got ready=%b want %0d", req_ready, exp_w);
      end
      last_g = exp_w;
      @(negedge clk); req_valid = 4'b0000; #1;
      total++;
      if ({tx_valid, grant_id} !== {1'b1, 2'd2}) begin
         bad++; $display("FAIL wrap_gid2: got txv=%b gid=%0d want 1/2", tx_valid, grant_id);
      end
      pulse_done();
   endtask

   task automatic test_timeout();
      int r = $urandom_range(0, 3);
      int r2;
      logic [7:0] dat = 8'($urandom);
      int seen = -1;
      logic b16 = 1'b0, b17 = 1'b1, e18 = 1'b1;
      @(negedge clk); req_data = $urandom; req_data[r*8 +: 8] = dat; req_valid = 4'(1 << r); #1;
      last_g = r;
      @(negedge clk); req_valid = 4'h0; #1;
      total++;
      if ({tx_valid, tx_data} !== {1'b1, dat}) begin
         bad++; $display("FAIL to_launch: got txv=%b data=%h want 1/%h", tx_valid, tx_data, dat);
      end
      for (int c = 1; c <= 20; c++) begin
         step();
         if (timeout_err === 1'b1 && seen < 0) seen = c;
         if (c == TO)     b16 = busy;
         if (c == TO + 1) b17 = busy;
         if (c == TO + 2) e18 = timeout_err;
      end
      total++;
      if (seen != TO + 1) begin
         bad++; $display("FAIL to_pulse_time: got cycle %0d want %0d", seen, TO + 1);
      end
      total++;
      if ({b16, b17, e18} !== 3'b100) begin
         bad++; $display("FAIL to_busy_pulse: got busy16=%b busy17=%b err18=%b want 1/0/0", b16, b17, e18);
      end
      r2 = $urandom_range(0, 3);
      dat = 8'($urandom);
      @(negedge clk); req_data[r2*8 +: 8] = dat; req_valid = 4'(1 << r2); #1;
      last_g = r2;
      @(negedge clk); req_valid = 4'h0; #1;
      total++;
      if ({tx_valid, tx_data, grant_id} !== {1'b1, dat, 2'(r2)}) begin
         bad++; $display("FAIL to_recover: got txv=%b data=%h gid=%0d want 1/%h/%0d",
                         tx_valid, tx_data, grant_id, dat, r2);
      end
      pulse_done();
   endtask

   task automatic test_done_terminal();
      int r = $urandom_range(0, 3);
      int errs = 0, bsy = 0, idle_bad = 0;
      @(negedge clk); req_data = $urandom; req_valid = 4'(1 << r); #1;
      last_g = r;
      @(negedge clk); req_valid = 4'h0; tx_done = 1'b1; #1;
      for (int c = 1; c < TO; c++) begin
         @(negedge clk); tx_done = 1'b0; #1;
         if (busy !== 1'b1) bsy++;
         if (timeout_err !== 1'b0) errs++;
      end
      @(negedge clk); tx_done = 1'b1; #1;
      @(negedge clk); tx_done = 1'b0; #1;
      total++;
      if (bsy != 0) begin
         bad++; $display("FAIL done_in_issue: got %0d idle cycles want 0", bsy);
      end
      total++;
      if ({busy, timeout_err} !== 2'b00 || errs != 0) begin
         bad++; $display("FAIL done_terminal: got busy=%b err=%b early=%0d want 0/0/0", busy, timeout_err, errs);
      end
      repeat (3) begin
         @(negedge clk); tx_done = 1'b1; #1;
         if ({busy, tx_valid, timeout_err} !== 3'b000) idle_bad++;
      end
      @(negedge clk); tx_done = 1'b0; #1;
      total++;
      if (idle_bad != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL done_in_idle: got %0d bad cycles busy=%b want 0/0", idle_bad, busy);
      end
   endtask

   task automatic test_reset_mid();
      int r = $urandom_range(0, 3);
      logic [7:0] dat = 8'($urandom);
      @(negedge clk); req_data = $urandom; req_valid = 4'(1 << r); #1;
      @(negedge clk); req_valid = 4'h0; #1;
      repeat (3) step();
      @(negedge clk); reset_n = 1'b0; #1;
      total++;
      if ({req_ready, tx_valid, busy, grant_id, tx_data, timeout_err} !== 16'h0) begin
         bad++; $display("FAIL rst_mid: got ready=%b txv=%b busy=%b gid=%0d data=%h err=%b want all zero",
                         req_ready, tx_valid, busy, grant_id, tx_data, timeout_err);
      end
      step();
      @(negedge clk); reset_n = 1'b1; #1;
      last_g = 3;
      @(negedge clk); req_data[31:24] = dat; req_valid = 4'b1000; #1;
      total++;
      if (req_ready !== 4'b1000) begin
         bad++; $display("FAIL rst_regrant: got ready=%b want 1000", req_ready);
      end
      @(negedge clk); req_valid = 4'h0; #1;
      total++;
      if ({tx_valid, grant_id, tx_data, timeout_err} !== {1'b1, 2'd3, dat, 1'b0}) begin
         bad++; $display("FAIL rst_launch: got txv=%b gid=%0d data=%h err=%b want 1/3/%h/0",
                         tx_valid, grant_id, tx_data, timeout_err, dat);
      end
      pulse_done();
   endtask

   task automatic test_random();
      logic [3:0] pending = 4'h0;
      int wait_bad = 0;
      for (int n = 0; n < 60; n++) begin
         int exp_w, d;
         logic [7:0] exp_d;
         pending |= 4'($urandom) & 4'($urandom);
         @(negedge clk); tx_done = 1'b0; req_valid = pending; req_data = $urandom; #1;
         if (pending == 4'h0) begin
            total++;
            if ({req_ready, busy} !== 5'b0) begin
               bad++; $display("FAIL rand_idle%0d: got ready=%b busy=%b want 0/0", n, req_ready, busy);
            end
            continue;
         end
         exp_w = rr_pick(pending, last_g);
         exp_d = req_data[exp_w*8 +: 8];
         total++;
         if (req_ready !== 4'(1 << exp_w)) begin
            bad++; $display("FAIL rand_grant%0d: got ready=%b want %0d (pend=%b)", n, req_ready, exp_w, pending);
         end
         last_g = exp_w;
         pending[exp_w] = 1'b0;
         @(negedge clk); req_valid = pending; req_data = $urandom; #1;
         total++;
         if ({tx_valid, tx_data, grant_id, req_ready} !== {1'b1, exp_d, 2'(exp_w), 4'h0}) begin
            bad++; $display("FAIL rand_launch%0d: got txv=%b data=%h gid=%0d ready=%b want 1/%h/%0d/0000",
                            n, tx_valid, tx_data, grant_id, req_ready, exp_d, exp_w);
         end
         d = $urandom_range(0, 5);
         repeat (d) begin
            step();
            if ({tx_valid, busy, req_ready, tx_data} !== {1'b0, 1'b1, 4'h0, exp_d}) wait_bad++;
         end
         @(negedge clk); tx_done = 1'b1; #1;
      end
      @(negedge clk); tx_done = 1'b0; req_valid = 4'h0; #1;
      total++;
      if (wait_bad != 0) begin
         bad++; $display("FAIL rand_wait: got %0d bad wait cycles want 0", wait_bad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_done_terminal();
      test_reset_mid();
      test_random();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
